// File: rtl/exec_sched_pkg.sv
// Shared types for the execute-stage sequencer: instruction class encoding,
// controller states and small sizing helpers.
package exec_sched_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MUL = 2'b01,
    CLS_DIV = 2'b10,
    CLS_ILL = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GO    = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/exec_sched_if.sv
// Issue (decode -> execute) and result (execute -> memory) handshakes.
// Both sides use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the producer holds valid and its payload
// steady until that edge, and ready may depend combinationally on valid.
interface exec_sched_if #(
  parameter int TAG_W = 5
);
  import exec_sched_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_rd;
  logic              out_illegal;

  // Execute-stage view
  modport slave (
    input  in_valid, in_class, in_tag, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_tag, out_rd, out_illegal
  );

  // Decode / memory-stage view
  modport master (
    output in_valid, in_class, in_tag, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_tag, out_rd, out_illegal
  );

endinterface

// File: rtl/exec_watchdog.sv
// Saturating wait counter with synchronous clear and a sticky timeout flag
// that sets on the edge where the count reaches MAX_WAIT.
module exec_watchdog
  import exec_sched_pkg::*;
#(
  parameter int MAX_WAIT = 40
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic err
);

  localparam int CW = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  // Next count: clear wins, otherwise count up while enabled, stopping at LIMIT
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en && (count != LIMIT)) begin
      count_nxt = count + 1'b1;
    end
  end

  // Counter register and sticky error (only reset clears the error)
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      if (count_nxt == LIMIT) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_sched.sv
// Execute-stage sequencer: accepts one op at a time, starts the ALU/MUL/DIV
// unit for its class, waits for that unit's done, and holds the result for
// the memory stage. Handles flush (draining an in-flight unit) and a sticky
// watchdog timeout.
// Optional: define EXEC_SCHED_PERF_EN to add perf_issued/perf_busy/perf_stall.
module exec_sched
  import exec_sched_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 40
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  exec_sched_if.slave       bus,
  output logic [DATA_W-1:0] op_rs1,
  output logic [DATA_W-1:0] op_rs2,
  output logic              alu_go,
  output logic              mul_go,
  output logic              div_go,
  input  logic              alu_done,
  input  logic              mul_done,
  input  logic              div_done,
  input  logic [DATA_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] mul_rd,
  input  logic [DATA_W-1:0] div_rd,
  output logic              busy,
`ifdef EXEC_SCHED_PERF_EN
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall,
`endif
  output logic              err_timeout
);

  state_e            state;
  cls_e              cls;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;
  logic              done_sel;
  logic [DATA_W-1:0] rd_sel;

  assign bus.in_ready = !flush && ((state == S_IDLE) ||
                                   ((state == S_HOLD) && bus.out_ready));
  assign accept      = bus.in_valid && bus.in_ready;
  assign busy        = (state != S_IDLE);
  assign bus.out_tag = tag_q;

  // Start pulses are decoded from the GO state so a flush in that same cycle
  // still cancels the start.
  assign alu_go = (state == S_GO) && !flush && (cls == CLS_ALU);
  assign mul_go = (state == S_GO) && !flush && (cls == CLS_MUL);
  assign div_go = (state == S_GO) && !flush && (cls == CLS_DIV);

  // Observe only the latched unit; the other units' done/rd are ignored
  always_comb begin
    done_sel = 1'b0;
    rd_sel   = '0;
    case (cls)
      CLS_ALU: begin done_sel = alu_done; rd_sel = alu_rd; end
      CLS_MUL: begin done_sel = mul_done; rd_sel = mul_rd; end
      CLS_DIV: begin done_sel = div_done; rd_sel = div_rd; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered operand, tag and result outputs
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state           <= S_IDLE;
      cls             <= CLS_ALU;
      op_rs1          <= '0;
      op_rs2          <= '0;
      tag_q           <= '0;
      bus.out_rd      <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (flush) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end else if (accept) begin
            cls    <= cls_e'(bus.in_class);
            op_rs1 <= bus.in_rs1;
            op_rs2 <= bus.in_rs2;
            tag_q  <= bus.in_tag;
            if (cls_e'(bus.in_class) == CLS_ILL) begin
              // No unit to run: the result is ready immediately
              state           <= S_HOLD;
              bus.out_valid   <= 1'b1;
              bus.out_rd      <= '0;
              bus.out_illegal <= 1'b1;
            end else begin
              state           <= S_GO;
              bus.out_valid   <= 1'b0;
              bus.out_illegal <= 1'b0;
            end
          end else if ((state == S_HOLD) && bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        S_GO: begin
          state <= flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            // A unit finishing in the flush cycle needs no draining
            state <= done_sel ? S_IDLE : S_DRAIN;
          end else if (done_sel) begin
            bus.out_rd    <= rd_sel;
            bus.out_valid <= 1'b1;
            state         <= S_HOLD;
          end
        end
        S_DRAIN: begin
          // Flush is ignored here; the unit's result is dropped
          if (done_sel) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  exec_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state == S_GO),
    .en   ((state == S_WAIT) || (state == S_DRAIN)),
    .err  (err_timeout)
  );

`ifdef EXEC_SCHED_PERF_EN
  // Free-running event counters, wrapping; untouched by flush
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      perf_issued <= '0;
      perf_busy   <= '0;
      perf_stall  <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(accept);
      perf_busy   <= perf_busy + 32'((state == S_GO) || (state == S_WAIT) ||
                                     (state == S_DRAIN));
      perf_stall  <= perf_stall + 32'(bus.out_valid && !bus.out_ready);
    end
  end
`endif

endmodule

// File: tb/tb_exec_sched.sv
// Bench for exec_sched: directed scenarios plus randomized traffic, with an
// expected-result queue filled at issue and drained by an output monitor.
module tb_exec_sched;
  import exec_sched_pkg::*;

  localparam int TAG_W    = 5;
  localparam int MAX_WAIT = 40;
  localparam int EXP_W    = 1 + TAG_W + 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] op_rs1, op_rs2;
  logic        alu_go, mul_go, div_go;
  logic        alu_done = 1'b0, mul_done = 1'b0, div_done = 1'b0;
  logic [31:0] alu_rd = '0, mul_rd = '0, div_rd = '0;
  logic        busy, err_timeout;

  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       cls_q[$];
  bit auto_units = 1'b0;

  exec_sched_if #(.TAG_W(TAG_W)) bus ();

  exec_sched #(.TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus.slave),
    .op_rs1(op_rs1), .op_rs2(op_rs2),
    .alu_go(alu_go), .mul_go(mul_go), .div_go(div_go),
    .alu_done(alu_done), .mul_done(mul_done), .div_done(div_done),
    .alu_rd(alu_rd), .mul_rd(mul_rd), .div_rd(div_rd),
    .busy(busy), .err_timeout(err_timeout)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference behaviour ----------------
  // Result each class should produce from its operands; illegal yields 0.
  function automatic logic [31:0] ref_rd(input logic [1:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a * b;
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [1:0] c, input logic [TAG_W-1:0] t,
                          input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.in_class = c;
    bus.in_tag   = t;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
  endtask

  // ---------------- unit models (random latency, active in auto mode) ----------------
  initial begin : unit_model
    int pend;
    int cnt;
    logic [31:0] res;
    pend = -1; cnt = 0; res = '0;
    forever begin
      @(negedge clk);
      if (rstn || !auto_units) pend = -1;
      else if (alu_go) begin pend = 0; cnt = $urandom_range(0, 1);  res = ref_rd(2'b00, op_rs1, op_rs2); end
      else if (mul_go) begin pend = 1; cnt = $urandom_range(0, 6);  res = ref_rd(2'b01, op_rs1, op_rs2); end
      else if (div_go) begin pend = 2; cnt = $urandom_range(0, 12); res = ref_rd(2'b10, op_rs1, op_rs2); end
      @(posedge clk);
      #1;
      if (auto_units) begin
        // stray pulses from idle units carry junk results
        alu_done = (pend != 0) && ($urandom_range(0, 5) == 0); alu_rd = $urandom;
        mul_done = (pend != 1) && ($urandom_range(0, 5) == 0); mul_rd = $urandom;
        div_done = (pend != 2) && ($urandom_range(0, 5) == 0); div_rd = $urandom;
        if (pend >= 0) begin
          if (cnt == 0) begin
            case (pend)
              0:       begin alu_done = 1'b1; alu_rd = res; end
              1:       begin mul_done = 1'b1; mul_rd = res; end
              default: begin div_done = 1'b1; div_rd = res; end
            endcase
            pend = -1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic prev_hold;
    logic [EXP_W-1:0] prev_out, got, want;
    logic [1:0] got_cls, want_cls;
    int ngo;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      got = {bus.out_illegal, bus.out_tag, bus.out_rd};
      if (rstn) begin
        exp_q.delete();
        cls_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (!bus.out_valid || (got !== prev_out)) begin
            errors++;
            $display("FAIL hold_stable got valid=%0b out=%h want valid=1 out=%h",
                     bus.out_valid, got, prev_out);
          end
        end
        ngo = int'(alu_go) + int'(mul_go) + int'(div_go);
        if (ngo > 0) begin
          got_cls = mul_go ? 2'b01 : (div_go ? 2'b10 : 2'b00);
          checks++;
          if (ngo > 1 || cls_q.size() == 0) begin
            errors++;
            $display("FAIL go_pulse got go=%0b%0b%0b pending=%0d want one go per issued op",
                     alu_go, mul_go, div_go, cls_q.size());
          end else begin
            want_cls = cls_q.pop_front();
            if (got_cls !== want_cls) begin
              errors++;
              $display("FAIL go_class got=%0d want=%0d", got_cls, want_cls);
            end
          end
        end
        if (bus.out_valid && bus.out_ready && !flush) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_extra got=%h want=no result", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL result got ill/tag/rd=%h want=%h", got, want);
            end
          end
        end
        if (flush) begin
          exp_q.delete();
          cls_q.delete();
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back({(bus.in_class == 2'b11), bus.in_tag,
                           ref_rd(bus.in_class, bus.in_rs1, bus.in_rs2)});
          if (bus.in_class != 2'b11) cls_q.push_back(bus.in_class);
        end
        prev_hold = bus.out_valid && !bus.out_ready && !flush;
        prev_out  = got;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int first_k;
    int sent;
    bit ok;
    bit last_acc;
    int r;
    logic [1:0] c;

    drive_op(1'b0, 2'b00, '0, '0, '0);
    bus.out_ready = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_out_valid", bus.out_valid, 0);
    check32("rst_busy", busy, 0);
    check32("rst_err", err_timeout, 0);
    check32("rst_go", {alu_go, mul_go, div_go}, 0);
    check32("rst_op_rs1", op_rs1, 0);
    check32("rst_out_rd", bus.out_rd, 0);
    check32("rst_out_tag", bus.out_tag, 0);
    check32("rst_in_ready", bus.in_ready, 1);
    step(); rstn = 1'b0;

    // ALU 5+7, done the cycle after go
    bus.out_ready = 1'b1;
    step(); drive_op(1'b1, 2'b00, 5'd9, 32'd5, 32'd7);
    @(negedge clk); check32("alu_accept", bus.in_ready, 1);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk); check32("alu_go_n1", {alu_go, mul_go, div_go}, 3'b100);
    check32("alu_valid_n1", bus.out_valid, 0);
    step(); alu_done = 1'b1; alu_rd = 32'd12;
    @(negedge clk); check32("alu_go_n2", alu_go, 0);
    check32("alu_valid_n2", bus.out_valid, 0);
    step(); alu_done = 1'b0;
    @(negedge clk); check32("alu_valid_n3", bus.out_valid, 1);
    check32("alu_rd", bus.out_rd, 32'd12);
    check32("alu_tag", bus.out_tag, 32'd9);
    step();
    @(negedge clk); check32("alu_idle", {busy, bus.out_valid}, 0);

    // DIV with 33-cycle latency and stray done pulses from other units
    step(); drive_op(1'b1, 2'b10, 5'd3, 32'd100, 32'd33);
    @(negedge clk); check32("div_accept", bus.in_ready, 1);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk); check32("div_go", {alu_go, mul_go, div_go}, 3'b001);
    ok = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      mul_done = (k == 5);  mul_rd = 32'h0000_0BAD;
      alu_done = (k == 10); alu_rd = 32'h0000_BAD2;
      div_done = (k == 33); div_rd = (k == 33) ? 32'd3 : 32'h0000_BAD3;
      @(negedge clk);
      if (k <= 33 && !(busy && !bus.in_ready && !bus.out_valid)) ok = 1'b0;
    end
    check32("div_wait_busy", ok, 1);
    check32("div_valid", bus.out_valid, 1);
    check32("div_rd", bus.out_rd, 32'd3);
    check32("div_no_timeout", err_timeout, 0);
    step();

    // HOLD for 4 stalled cycles, then back-to-back MUL issue
    bus.out_ready = 1'b0;
    step(); drive_op(1'b1, 2'b00, 5'd4, 32'd1, 32'd2);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    step(); alu_done = 1'b1; alu_rd = 32'd3;
    step(); alu_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32("hold_valid", {bus.out_valid, bus.out_rd}, {1'b1, 32'd3});
      step();
    end
    bus.out_ready = 1'b1;
    drive_op(1'b1, 2'b01, 5'd6, 32'd6, 32'd7);
    @(negedge clk); check32("b2b_accept", {bus.in_ready, bus.out_valid}, 2'b11);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk); check32("b2b_mul_go", {alu_go, mul_go, div_go, bus.out_valid}, 4'b0100);
    step(); mul_done = 1'b1; mul_rd = 32'd42;
    step(); mul_done = 1'b0;
    @(negedge clk); check32("b2b_mul_rd", {bus.out_valid, bus.out_rd}, {1'b1, 32'd42});
    step();

    // Flush during MUL WAIT, done 3 cycles later drains to IDLE
    step(); drive_op(1'b1, 2'b01, 5'd7, 32'd3, 32'd4);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    step();
    step(); flush = 1'b1;
    @(negedge clk); check32("flush_in_ready", bus.in_ready, 0);
    step(); flush = 1'b0; drive_op(1'b1, 2'b00, 5'd8, 32'd1, 32'd1);
    @(negedge clk); check32("drain_1", {busy, bus.in_ready, bus.out_valid}, 3'b100);
    step(); flush = 1'b1;
    @(negedge clk); check32("drain_2", {busy, bus.in_ready, bus.out_valid}, 3'b100);
    step(); flush = 1'b0; mul_done = 1'b1; mul_rd = 32'd99;
    @(negedge clk); check32("drain_3", {busy, bus.in_ready, bus.out_valid}, 3'b100);
    step(); mul_done = 1'b0; drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk); check32("drain_idle", {busy, bus.out_valid}, 0);

    // Flush in WAIT together with done returns straight to IDLE
    step(); drive_op(1'b1, 2'b01, 5'd10, 32'd2, 32'd2);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    step(); flush = 1'b1; mul_done = 1'b1; mul_rd = 32'd4;
    step(); flush = 1'b0; mul_done = 1'b0;
    @(negedge clk); check32("flush_done_idle", {busy, bus.out_valid}, 0);

    // Illegal class
    step(); drive_op(1'b1, 2'b11, 5'd17, 32'd123, 32'd456);
    @(negedge clk); check32("ill_accept", bus.in_ready, 1);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk);
    check32("ill_out", {bus.out_valid, bus.out_illegal, bus.out_rd}, {2'b11, 32'd0});
    check32("ill_no_go", {alu_go, mul_go, div_go}, 0);
    step();
    @(negedge clk); check32("ill_idle", {busy, bus.out_valid}, 0);

    // Watchdog: MUL done withheld 50 cycles
    step(); drive_op(1'b1, 2'b01, 5'd20, 32'd9, 32'd9);
    step(); drive_op(1'b0, 2'b00, '0, '0, '0);
    @(negedge clk); check32("wd_mul_go", mul_go, 1);
    first_k = -1;
    for (int k = 1; k <= 52; k++) begin
      step(); mul_done = (k == 50); mul_rd = 32'd81;
      @(negedge clk);
      if (err_timeout && first_k < 0) first_k = k;
    end
    checks++;
    if (!(first_k == 40 || first_k == 41)) begin
      errors++;
      $display("FAIL wd_rise got=%0d cycles after go want=40..41", first_k);
    end
    check32("wd_sticky", {err_timeout, busy}, 2'b10);
    step(); rstn = 1'b1;
    @(negedge clk); check32("wd_cleared", err_timeout, 0);
    step(); rstn = 1'b0;
    @(negedge clk); check32("wd_after_rst", {err_timeout, busy}, 0);

    // Randomized traffic with random unit latency and memory backpressure
    auto_units = 1'b1;
    alu_done = 1'b0; mul_done = 1'b0; div_done = 1'b0;
    sent = 0;
    last_acc = 1'b0;
    for (int cyc = 0; cyc < 6000 && sent < 200; cyc++) begin
      step();
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          r = $urandom_range(0, 9);
          c = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
          drive_op(1'b1, c, TAG_W'($urandom), $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
        end else begin
          drive_op(1'b0, 2'b00, '0, '0, '0);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_acc = bus.in_valid && bus.in_ready;
      if (last_acc) sent++;
    end
    step(); drive_op(1'b0, 2'b00, '0, '0, '0); bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    check32("rand_issued", sent, 200);
    check32("rand_drained", (exp_q.size() == 0) && !busy, 1);
    check32("rand_no_timeout", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
